// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register sequencer.
// Holds the command ops, datapath selects and FSM state enum.
package usr_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SHL   = 2'b01;
  localparam logic [1:0] OP_SHR   = 2'b10;
  localparam logic [1:0] OP_ROTR  = 2'b11;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHL  = 2'b01;
  localparam logic [1:0] SEL_SHR  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/usr_core.sv
// WIDTH-bit universal shift register: hold, shift left, shift right, or parallel load.
// One-edge latency per operation; no backpressure, acts on sel every cycle.
module usr_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic             fill_lo,
  input  logic             fill_hi,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (sel)
        SEL_SHL:  q <= {q[WIDTH-2:0], fill_lo};
        SEL_SHR:  q <= {fill_hi, q[WIDTH-1:1]};
        SEL_LOAD: q <= din;
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/usr_sequencer.sv
// Command sequencer driving usr_core: LOAD, SHL N, SHR N, ROTR N; done pulses after the last edge.
// LOAD takes 3 cycles accept-to-ready, shifts N+2; cmd_ready only in IDLE, busy commands are dropped.
module usr_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0]   cmd_data,
  input  logic               serial_in,
  output logic [WIDTH-1:0]   q,
  output logic               serial_out,
  output logic               serial_out_valid,
  output logic               busy,
  output logic               done
);

  state_t             state, state_nxt;
  logic [1:0]         op_r;
  logic [COUNT_W-1:0] rem;
  logic [WIDTH-1:0]   data_r;
  logic [1:0]         sel;
  logic               fill_hi;
  logic               shifting;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      op_r   <= OP_LOAD;
      rem    <= '0;
      data_r <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && cmd_valid) begin
        op_r   <= cmd_op;
        rem    <= cmd_count;
        data_r <= cmd_data;
      end else if (shifting) begin
        rem <= rem - COUNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    sel       = SEL_HOLD;
    shifting  = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (op_r == OP_LOAD) begin
          sel       = SEL_LOAD;
          state_nxt = ST_DONE;
        end else if (rem == '0) begin
          state_nxt = ST_DONE;
        end else begin
          shifting = 1'b1;
          sel      = (op_r == OP_SHL) ? SEL_SHL : SEL_SHR;
          if (rem == COUNT_W'(1)) state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Rotate right is a right shift whose fill is the bit falling out of q[0].
  assign fill_hi          = (op_r == OP_ROTR) ? q[0] : serial_in;
  assign serial_out       = shifting & ((op_r == OP_SHL) ? q[WIDTH-1] : q[0]);
  assign serial_out_valid = shifting;
  assign busy             = (state != ST_IDLE);
  assign done             = (state == ST_DONE);

  usr_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .sel     (sel),
    .fill_lo (serial_in),
    .fill_hi (fill_hi),
    .din     (data_r),
    .q       (q)
  );

endmodule

// File: tb/tb_usr_sequencer.sv
// Directed bench for usr_sequencer with hand-computed expectations, sampled on the falling edge.
module tb_usr_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_count = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic       serial_in = 1'b0;
  logic [3:0] q;
  logic       serial_out;
  logic       serial_out_valid;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] q_at [0:31];

  int         done_cyc, ready_cyc, ndone, nsov;
  logic [15:0] so_bits;

  always #5 clk = ~clk;

  usr_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_count        (cmd_count),
    .cmd_data         (cmd_data),
    .serial_in        (serial_in),
    .q                (q),
    .serial_out       (serial_out),
    .serial_out_valid (serial_out_valid),
    .busy             (busy),
    .done             (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command from a falling edge; returns just after the accept edge k.
  task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    check("ready_at_issue", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Sample cycle c (interval between edges k+c-1 and k+c) until cmd_ready returns.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data);
    issue(op, cnt, data);
    done_cyc = -1; ready_cyc = -1; ndone = 0; nsov = 0; so_bits = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      q_at[c] = q;
      if (serial_out_valid) begin
        so_bits = {so_bits[14:0], serial_out};
        nsov++;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (cmd_ready) begin
        ready_cyc = c;
        break;
      end
    end
    if (ready_cyc < 0) check("timeout_ready", 0, 1);
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_q", q, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sov", serial_out_valid, 1'b0);
    check("rst_so", serial_out, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1'b1);

    // LOAD 1011
    run_cmd(2'b00, 3'd0, 4'b1011);
    check("load_q_c1", q_at[1], 4'b0000);
    check("load_q_c2", q_at[2], 4'b1011);
    check("load_done_cyc", done_cyc, 2);
    check("load_ndone", ndone, 1);
    check("load_ready_cyc", ready_cyc, 3);
    check("load_nsov", nsov, 0);

    // SHL 2 with serial_in=1 from 1011
    serial_in = 1'b1;
    run_cmd(2'b01, 3'd2, 4'b0000);
    check("shl_q_c2", q_at[2], 4'b0111);
    check("shl_q_c3", q_at[3], 4'b1111);
    check("shl_so", so_bits, 16'b10);
    check("shl_nsov", nsov, 2);
    check("shl_done_cyc", done_cyc, 3);
    check("shl_ready_cyc", ready_cyc, 4);

    // LOAD 1001 then ROTR 5 (wraps past WIDTH), serial_in must not matter
    run_cmd(2'b00, 3'd0, 4'b1001);
    check("load2_q", q, 4'b1001);
    serial_in = 1'b1;
    run_cmd(2'b11, 3'd5, 4'b0000);
    check("rotr_q", q, 4'b1100);
    check("rotr_so", so_bits, 16'b10011);
    check("rotr_nsov", nsov, 5);
    check("rotr_done_cyc", done_cyc, 6);
    check("rotr_ndone", ndone, 1);

    // SHR 0 with cmd_valid held through busy
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_count = 3'd0; cmd_data = 4'b0101;
    check("shr0_ready_issue", cmd_ready, 1'b1);
    @(posedge clk);
    ndone = 0; nsov = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (serial_out_valid) nsov++;
      check("shr0_q", q, 4'b1100);
      if (c == 1) check("shr0_busy_c1", {busy, cmd_ready}, 2'b10);
      if (c == 2) check("shr0_done_c2", {done, cmd_ready}, 2'b10);
      if (c == 3) check("shr0_idle_c3", {busy, cmd_ready}, 2'b01);
      if (c == 4) check("shr0_reaccept_c4", {busy, done}, 2'b10);
    end
    cmd_valid = 1'b0;
    check("shr0_ndone", ndone, 1);
    check("shr0_nsov", nsov, 0);
    @(negedge clk);
    check("shr0_second_done", done, 1'b1);
    @(negedge clk);
    check("shr0_ready_end", cmd_ready, 1'b1);

    // SHL 6 from 1111 with serial_in=0, reset after 2 shifts
    run_cmd(2'b00, 3'd0, 4'b1111);
    serial_in = 1'b0;
    issue(2'b01, 3'd6, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort_q_pre", q, 4'b1100);
    rst = 1'b1;
    #1;
    check("abort_q", q, 4'b0000);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_ready", cmd_ready, 1'b1);

    // Normal operation after abort: LOAD 0110, SHR 3 with serial_in=1
    run_cmd(2'b00, 3'd0, 4'b0110);
    check("post_load_q", q, 4'b0110);
    serial_in = 1'b1;
    run_cmd(2'b10, 3'd3, 4'b0000);
    check("shr_q", q, 4'b1110);
    check("shr_so", so_bits, 16'b011);
    check("shr_done_cyc", done_cyc, 4);

    // SHL 7 (count > WIDTH) with serial_in=0 flushes to the fill history
    serial_in = 1'b0;
    run_cmd(2'b01, 3'd7, 4'b0000);
    check("shl7_q", q, 4'b0000);
    check("shl7_nsov", nsov, 7);
    check("shl7_so", so_bits, 16'b1110000);
    check("shl7_done_cyc", done_cyc, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usr_sequencer.md
# usr_sequencer

Command-driven sequencer for a WIDTH-bit universal shift register. It accepts one command at a time over a valid/ready handshake: load, shift left N, shift right N, or rotate right N. It drives the register's mode select and serial inputs cycle by cycle, counts the shifts, presents each shifted-out bit, and pulses `done` on completion. It sits between a host/control FSM and the shift datapath; the datapath is instantiated inside the block.

## Interface
- `WIDTH`, default 4, register width in bits (≥2).
- `COUNT_W`, default 3, width of the shift-count field; maximum count is 2^COUNT_W−1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command (IDLE only).
- `cmd_op` input 2: operation. 00 LOAD, 01 SHL, 10 SHR, 11 ROTR.
- `cmd_count` input COUNT_W: number of shift steps; ignored for LOAD.
- `cmd_data` input WIDTH: parallel load value; used by LOAD only.
- `serial_in` input 1: fill bit for SHL (enters bit 0) and SHR (enters bit WIDTH−1). Sampled on each shift edge.
- `q` output WIDTH: register contents.
- `serial_out` output 1: bit leaving the register on the current shift edge. For SHL it is `q[WIDTH-1]`; for SHR and ROTR it is `q[0]`. It is 0 when not shifting.
- `serial_out_valid` output 1: high in every cycle whose closing edge performs a shift.
- `busy` output 1: command in progress (EXEC or DONE).
- `done` output 1: one-cycle completion pulse.

## Operation
- States: IDLE, EXEC, DONE.
- **IDLE**
  - `cmd_ready=1`; datapath select = HOLD.
  - On `cmd_valid && cmd_ready`, latch `cmd_op`, `cmd_count` into a remaining counter `rem`, and `cmd_data`, then go to EXEC.
- **EXEC, LOAD**
  - Select = LOAD for exactly one edge; `q <= data_latched`; go to DONE.
- **EXEC, SHL/SHR/ROTR with rem>0**
  - Select = the shift mode; one shift per edge; `rem` decrements.
  - When `rem==1` at the edge, go to DONE.
- **EXEC, shift op with rem==0 on entry**
  - Select = HOLD; `q` unchanged; go to DONE next edge.
- **Shift behaviour**
  - SHL: `q <= {q[WIDTH-2:0], serial_in}`.
  - SHR: `q <= {serial_in, q[WIDTH-1:1]}`.
  - ROTR: `q <= {q[0], q[WIDTH-1:1]}`; `serial_in` is ignored.
- **DONE**
  - `done=1` for one cycle; select = HOLD; go to IDLE.
- Counts greater than WIDTH are legal. Shifting continues for the full count: SHL/SHR end with all bits equal to the fill history, and ROTR wraps modulo WIDTH.
- `cmd_valid` while busy is ignored; the command is not latched and must be re-presented.
- `cmd_*` inputs need only be stable in the accept cycle.

## Timing
- Reset values: state IDLE; `q=0`, `rem=0`, `done=0`, `busy=0`, `serial_out=0`, `serial_out_valid=0`. `cmd_ready=1` while in IDLE after reset.
- Reset mid-command: the command is abandoned immediately, `q` clears, and no `done` is issued.
- Accept on edge k:
  - LOAD: `q` valid after edge k+1; `done` high in cycle k+1..k+2.
  - Shift of N≥1: shifts occur on edges k+1..k+N; `done` high in cycle k+N..k+N+1.
  - N=0: `done` high in cycle k+1..k+2.
- `cmd_ready` returns on edge after `done`. Minimum command spacing is 3 cycles for LOAD and N+2 cycles otherwise.
- `serial_out`/`serial_out_valid` are combinational from state and `q`. They are valid before the edge that performs the shift.
- `busy` = state≠IDLE; `done` is registered state decode (no glitch).

## Structure
- Package `usr_pkg`:
  - Op encodings OP_LOAD/OP_SHL/OP_SHR/OP_ROTR.
  - Datapath select encodings SEL_HOLD=00, SEL_SHL=01, SEL_SHR=10, SEL_LOAD=11.
  - State enum.
- Sub-module `usr_core`: the WIDTH-bit universal shift register.
  - Inputs: select, left fill, right fill, parallel input.
  - Asynchronous active-high reset.
  - ROTR is realised by the sequencer feeding `q[0]` as the right-shift fill with select SEL_SHR.
- The sequencer holds only the FSM, `rem` counter, and command latches.

## Test plan
- Reset: assert `rst` mid-cycle with no clock → `q=0`, `busy=0`, `done=0`. After release, `cmd_ready=1`.
- LOAD `cmd_data=1011` → `q=1011` after edge k+1. `done` pulses once; `cmd_ready` returns at k+3.
- After LOAD 1011, SHL count 2, `serial_in=1`:
  - `q`: 0111, then 1111.
  - `serial_out`: 1, then 0.
  - `serial_out_valid` is high for exactly 2 cycles.
- LOAD 1001, ROTR count 5 → `q=1100`. `done` is in cycle k+5..k+6, and `serial_out` sequence is 1,0,0,1,1.
- SHR count 0 with `cmd_valid` held high through busy:
  - `q` unchanged and `done` at k+1.
  - The held command is re-accepted only once IDLE is reached.
- SHL count 6 from 1111 with `serial_in=0`; assert `rst` after 2 shifts → `q=0` immediately. No `done`, and the next command executes normally.
